// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module  : data_mem
// Brief   : Byte-enabled RV32 data memory. Defining DMEM_MMIO_EN adds the MMIO
//           window (sticky TOHOST register, 4-entry TX character FIFO).
// Revision: 1.0
// ============================================================================
module data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready
);
    localparam int c_AW = $clog2(DEPTH_WORDS);

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic            w_ram_hit;
    logic [c_AW-1:0] w_idx;
    logic [3:0]      w_lane_mask;
    logic [31:0]     w_lane_data;
    logic [31:0]     w_mmio_rdata;
    logic            w_unused;

    // BASE_ADDR is aligned to the RAM size, so a hit is a match on the upper bits.
    assign w_ram_hit = (addr[31:c_AW+2] == BASE_ADDR[31:c_AW+2]);
    assign w_idx     = addr[c_AW+1:2];

    always_comb begin
        w_lane_mask = 4'b0000;
        w_lane_data = wdata;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                w_lane_mask = be;
                w_lane_data = {4{wdata[7:0]}};
            end
            4'b0011, 4'b1100: begin
                w_lane_mask = be;
                w_lane_data = {2{wdata[15:0]}};
            end
            4'b1111: begin
                w_lane_mask = 4'b1111;
                w_lane_data = wdata;
            end
            default: w_lane_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

    assign rdata = w_ram_hit ? r_mem[w_idx] : w_mmio_rdata;

`ifdef DMEM_MMIO_EN
    logic        w_mmio_hit;
    logic        w_mmio_wr;
    logic        w_push_req;
    logic        w_pop;
    logic        w_push;
    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        r_overflow;
    logic        r_tohost_valid;
    logic [31:0] r_tohost_data;

    assign w_mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    assign w_mmio_wr  = we && w_mmio_hit && (be != 4'b0000);
    assign w_push_req = w_mmio_wr && (addr[3:2] == 2'd1);
    assign w_pop      = (r_count != 3'd0) && char_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && ((r_count != 3'd4) || w_pop);

    always_comb begin
        w_mmio_rdata = 32'h0;
        if (w_mmio_hit) begin
            case (addr[3:2])
                2'd0:    w_mmio_rdata = r_tohost_data;
                2'd2:    w_mmio_rdata = {28'h0, r_overflow, r_count};
                default: w_mmio_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_wptr         <= 2'd0;
            r_rptr         <= 2'd0;
            r_count        <= 3'd0;
            r_overflow     <= 1'b0;
            r_tohost_valid <= 1'b0;
            r_tohost_data  <= 32'h0;
        end else begin
            if (w_mmio_wr && (addr[3:2] == 2'd0) && !r_tohost_valid) begin
                r_tohost_valid <= 1'b1;
                r_tohost_data  <= wdata;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_push) begin
                r_fifo[r_wptr] <= wdata[7:0];
                r_wptr         <= r_wptr + 2'd1;
            end else if (w_push_req) begin
                r_overflow <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    assign tohost_valid = r_tohost_valid;
    assign tohost_data  = r_tohost_data;
    assign char_valid   = (r_count != 3'd0);
    assign char_data    = (r_count != 3'd0) ? r_fifo[r_rptr] : 8'h00;
    assign w_unused     = ^addr[1:0];
`else
    assign w_mmio_rdata = 32'h0;
    assign tohost_valid = 1'b0;
    assign tohost_data  = 32'h0;
    assign char_valid   = 1'b0;
    assign char_data    = 8'h00;
    assign w_unused     = ^{char_ready, addr[1:0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem
// Brief   : Self-checking bench for data_mem against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_data_mem;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO  = 32'h1000_0000;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;

    always #5 clk = ~clk;

    data_mem #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .MMIO_BASE  (MMIO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .be          (be),
        .rdata       (rdata),
        .tohost_valid(tohost_valid),
        .tohost_data (tohost_data),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_mem [DEPTH];
    logic        m_tv;
    logic [31:0] m_td;
    logic        m_ov;
    logic [7:0]  m_q [$];
    logic [3:0]  be_tab [12] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                 4'hC, 4'hF, 4'h5, 4'h6, 4'h9, 4'h7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return MMIO_EN && (a >= MMIO) && ((a - MMIO) < 32'd16);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (in_ram(a)) return m_mem[(a - BASE) >> 2];
        if (in_mmio(a)) begin
            case ((a - MMIO) >> 2)
                32'd0:   return m_td;
                32'd2:   return {28'h0, m_ov, 3'(m_q.size())};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // Model state update for the rising edge that ends a cycle with these inputs.
    task automatic m_commit(input logic [31:0] a, input logic [31:0] wd, input logic w,
                            input logic [3:0] b, input logic rdy);
        bit push;
        bit pop;
        push = 1'b0;
        if (w && in_ram(a)) begin
            logic [31:0] v;
            v = m_mem[(a - BASE) >> 2];
            case (b)
                4'b0001: v[7:0]   = wd[7:0];
                4'b0010: v[15:8]  = wd[7:0];
                4'b0100: v[23:16] = wd[7:0];
                4'b1000: v[31:24] = wd[7:0];
                4'b0011: v[15:0]  = wd[15:0];
                4'b1100: v[31:16] = wd[15:0];
                4'b1111: v        = wd;
                default: ;
            endcase
            m_mem[(a - BASE) >> 2] = v;
        end
        if (w && in_mmio(a) && (b != 4'b0000)) begin
            if (((a - MMIO) >> 2) == 32'd0 && !m_tv) begin
                m_tv = 1'b1;
                m_td = wd;
            end
            if (((a - MMIO) >> 2) == 32'd1) push = 1'b1;
        end
        pop = (m_q.size() > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 4) m_q.push_back(wd[7:0]);
            else m_ov = 1'b1;
        end
    endtask

    // Drive one cycle (entered just after a rising edge), check, then clock it.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic [3:0] b, input logic rdy, input bit chk_rd);
        addr = a; wdata = wd; we = w; be = b; char_ready = rdy;
        #1;
        if (chk_rd) chk("rdata", rdata, m_read(a));
        chk("tohost_valid", 32'(tohost_valid), 32'(m_tv));
        chk("tohost_data", tohost_data, m_td);
        chk("char_valid", 32'(char_valid), 32'(m_q.size() > 0));
        chk("char_data", 32'(char_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        @(posedge clk);
        #1;
        m_commit(a, wd, w, b, rdy);
    endtask

    task automatic do_reset();
        we = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_async_tohost_valid", 32'(tohost_valid), 32'h0);
        chk("rst_async_tohost_data", tohost_data, 32'h0);
        chk("rst_async_char_valid", 32'(char_valid), 32'h0);
        chk("rst_async_char_data", 32'(char_data), 32'h0);
        m_tv = 1'b0; m_td = 32'h0; m_ov = 1'b0; m_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        addr = 32'h0; wdata = 32'h0; we = 1'b0; be = 4'h0; char_ready = 1'b0;
        reset_n = 1'b0;
        m_tv = 1'b0; m_td = 32'h0; m_ov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tohost_valid", 32'(tohost_valid), 32'h0);
        chk("rst_tohost_data", tohost_data, 32'h0);
        chk("rst_char_valid", 32'(char_valid), 32'h0);
        chk("rst_char_data", 32'(char_data), 32'h0);
        addr = MMIO + 32'h8;
        #1;
        chk("rst_status", rdata, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) step(BASE + 32'(4 * i), $urandom, 1'b1, 4'hF, 1'b0, 1'b0);

        // word then byte store
        step(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0, 1'b1);
        step(32'h12, 32'h000000AA, 1'b1, 4'b0100, 1'b0, 1'b1);
        step(32'h10, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("sb_merge", rdata, 32'hDEAABEEF);

        // half store high, then an illegal enable pattern
        step(32'h20, 32'h0, 1'b1, 4'hF, 1'b0, 1'b1);
        step(32'h20, 32'h00001234, 1'b1, 4'b1100, 1'b0, 1'b1);
        step(32'h20, 32'hFFFFFFFF, 1'b1, 4'b0101, 1'b0, 1'b1);
        we = 1'b0;
        #1;
        chk("sh_high_illegal_be", rdata, 32'h12340000);

        // read during write
        step(32'h30, 32'h11, 1'b1, 4'hF, 1'b0, 1'b1);
        addr = 32'h30; wdata = 32'h55; we = 1'b1; be = 4'hF;
        #1;
        chk("rdw_old", rdata, 32'h11);
        @(posedge clk);
        #1;
        m_commit(32'h30, 32'h55, 1'b1, 4'hF, 1'b0);
        we = 1'b0;
        #1;
        chk("rdw_new", rdata, 32'h55);

        // just past the end of RAM
        step(BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 1'b1, 4'hF, 1'b0, 1'b1);
        chk("oor_read", rdata, 32'h0);
        step(BASE, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);

        // TOHOST capture is first-write-only
        step(MMIO, 32'h1, 1'b1, 4'hF, 1'b0, 1'b1);
        step(MMIO, 32'h7, 1'b1, 4'hF, 1'b0, 1'b1);
        step(MMIO, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("tohost_first_valid", 32'(tohost_valid), 32'(MMIO_EN));
        chk("tohost_first_data", tohost_data, MMIO_EN ? 32'h1 : 32'h0);
        do_reset();

        // overflow, then drain
        for (int i = 0; i < 5; i++) step(MMIO + 32'h4, 32'(8'h41 + i), 1'b1, 4'hF, 1'b0, 1'b1);
        addr = MMIO + 32'h8; we = 1'b0;
        #1;
        chk("status_overflow", rdata, MMIO_EN ? 32'h0000000C : 32'h0);
        chk("head_A", 32'(char_data), MMIO_EN ? 32'h41 : 32'h0);
        for (int i = 0; i < 5; i++) step(32'h40, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("drained", 32'(char_valid), 32'h0);

        // push into full FIFO with a simultaneous pop
        do_reset();
        for (int i = 0; i < 4; i++) step(MMIO + 32'h4, 32'(8'h30 + i), 1'b1, 4'hF, 1'b0, 1'b1);
        step(MMIO + 32'h4, 32'h58, 1'b1, 4'hF, 1'b1, 1'b1);
        addr = MMIO + 32'h8; we = 1'b0;
        #1;
        chk("status_push_pop", rdata, MMIO_EN ? 32'h00000004 : 32'h0);
        for (int i = 0; i < 5; i++) step(MMIO + 32'h8, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
                2:       a = MMIO + 32'($urandom_range(0, 15));
                default: a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                                         : MMIO + 32'd16 + 32'($urandom_range(0, 15));
            endcase
            step(a, $urandom, 1'($urandom), be_tab[$urandom_range(0, 11)],
                 1'($urandom_range(0, 2) == 0), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
